// File: rtl/bridge_arbiter.sv
// Two-master arbiter sharing the bridge processor port between CPU and DMA.
// CPU has default priority; starvation and locked bursts favour DMA.
module bridge_arbiter #(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned BURST_MAX  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wd,
  output logic [31:0] cpu_rd,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wd,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [31:0] dma_rd,
  output logic [31:0] PrAddr,
  output logic [31:0] PrWD,
  output logic        PrWE,
  input  logic [31:0] PrRD
);

  typedef enum logic {
    S_SHARED = 1'b0,
    S_BURST  = 1'b1
  } state_t;

  localparam logic [3:0] LP_STARVE    = 4'(STARVE_MAX);
  localparam logic [4:0] LP_BURST     = 5'(BURST_MAX);
  localparam logic       LP_CAN_BURST = (BURST_MAX > 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_wait_cnt;
  logic [3:0]  w_wait_nxt;
  logic [3:0]  r_beat_cnt;
  logic [3:0]  w_beat_nxt;
  logic        r_dma_ack;
  logic [31:0] r_dma_rd;
  logic        w_starved;
  logic        w_cpu_gnt;
  logic        w_dma_gnt;

  always_comb begin
    w_starved = dma_req && (r_wait_cnt == LP_STARVE);
    w_dma_gnt = 1'b0;
    w_cpu_gnt = 1'b0;
    if (!reset) begin
      if (r_state == S_BURST) begin
        w_dma_gnt = dma_req;
        w_cpu_gnt = cpu_req && !dma_req;
      end else begin
        w_dma_gnt = w_starved || (dma_req && !cpu_req);
        w_cpu_gnt = cpu_req && !w_dma_gnt;
      end
    end
  end

  always_comb begin
    PrAddr = 32'd0;
    PrWD   = 32'd0;
    PrWE   = 1'b0;
    unique case (1'b1)
      w_dma_gnt: begin
        PrAddr = dma_addr;
        PrWD   = dma_wd;
        PrWE   = dma_we;
      end
      w_cpu_gnt: begin
        PrAddr = cpu_addr;
        PrWD   = cpu_wd;
        PrWE   = cpu_we;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat_cnt;
    w_wait_nxt  = r_wait_cnt;
    if (w_dma_gnt || !dma_req)
      w_wait_nxt = 4'd0;
    else if (r_wait_cnt < LP_STARVE)
      w_wait_nxt = r_wait_cnt + 4'd1;
    unique case (r_state)
      S_SHARED: begin
        if (w_dma_gnt && dma_lock && LP_CAN_BURST) begin
          w_state_nxt = S_BURST;
          w_beat_nxt  = 4'd1;
        end
      end
      S_BURST: begin
        // widened compare so beat_cnt+1 cannot wrap
        if (w_dma_gnt && dma_lock &&
            ({1'b0, r_beat_cnt} + 5'd1 < LP_BURST)) begin
          w_beat_nxt = r_beat_cnt + 4'd1;
        end else begin
          w_state_nxt = S_SHARED;
          w_beat_nxt  = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_SHARED;
      r_wait_cnt <= 4'd0;
      r_beat_cnt <= 4'd0;
      r_dma_ack  <= 1'b0;
      r_dma_rd   <= 32'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_dma_ack  <= w_dma_gnt;
      if (w_dma_gnt)
        r_dma_rd <= PrRD;
    end
  end

  assign cpu_rd    = PrRD;
  assign cpu_stall = cpu_req && !w_cpu_gnt;
  assign dma_gnt   = w_dma_gnt;
  assign dma_ack   = r_dma_ack;
  assign dma_rd    = r_dma_rd;

endmodule

// File: tb/tb_bridge_arbiter.sv
// Scoreboard bench for bridge_arbiter: directed test-plan sequences
// followed by randomized traffic against a behavioural model.
module tb_bridge_arbiter;

  localparam int SM = 8;
  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_lock, dma_we;
  logic [31:0] cpu_addr, cpu_wd, dma_addr, dma_wd, PrRD;
  logic [31:0] cpu_rd, dma_rd, PrAddr, PrWD;
  logic        cpu_stall, dma_gnt, dma_ack, PrWE;

  always #5 clk = ~clk;

  bridge_arbiter #(.STARVE_MAX(SM), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wd(dma_wd), .dma_gnt(dma_gnt),
    .dma_ack(dma_ack), .dma_rd(dma_rd),
    .PrAddr(PrAddr), .PrWD(PrWD), .PrWE(PrWE), .PrRD(PrRD)
  );

  typedef struct {
    logic        stall;
    logic        gnt;
    logic        we;
    logic        ack;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] crd;
    logic [31:0] drd;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Model: denied-cycle count and length of the current locked DMA chain.
  int          m_denied = 0;
  int          m_chain  = 0;
  logic        m_ack    = 1'b0;
  logic [31:0] m_rd     = 32'd0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endfunction

  task automatic step(
    input  logic        rst,
    input  logic        creq, cwe,
    input  logic [31:0] caddr, cwd,
    input  logic        dreq, dlock, dwe,
    input  logic [31:0] daddr, dwd, prrd,
    output logic        granted
  );
    exp_t e;
    logic dg, cg, burst;
    @(posedge clk);
    #1;
    reset = rst; cpu_req = creq; cpu_we = cwe;
    cpu_addr = caddr; cpu_wd = cwd;
    dma_req = dreq; dma_lock = dlock; dma_we = dwe;
    dma_addr = daddr; dma_wd = dwd; PrRD = prrd;
    burst = (m_chain > 0) && (m_chain < BM);
    if (rst) begin
      dg = 1'b0; cg = 1'b0;
    end else if (burst) begin
      dg = dreq; cg = creq && !dreq;
    end else begin
      dg = dreq && (m_denied >= SM || !creq);
      cg = creq && !dg;
    end
    e.stall = creq && !cg;
    e.gnt   = dg;
    e.addr  = dg ? daddr : (cg ? caddr : 32'd0);
    e.wd    = dg ? dwd : (cg ? cwd : 32'd0);
    e.we    = dg ? dwe : (cg ? cwe : 1'b0);
    e.crd   = prrd;
    e.ack   = m_ack;
    e.drd   = m_rd;
    q.push_back(e);
    if (rst) begin
      m_denied = 0; m_chain = 0; m_ack = 1'b0; m_rd = 32'd0;
    end else begin
      m_denied = (dg || !dreq) ? 0 : (m_denied < SM ? m_denied + 1 : SM);
      m_chain  = (dg && dlock) ? (m_chain % BM) + 1 : 0;
      m_ack    = dg;
      if (dg) m_rd = prrd;
    end
    granted = dg;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
        chk("dma_gnt",   32'(dma_gnt),   32'(e.gnt));
        chk("PrWE",      32'(PrWE),      32'(e.we));
        chk("PrAddr",    PrAddr,         e.addr);
        chk("PrWD",      PrWD,           e.wd);
        chk("cpu_rd",    cpu_rd,         e.crd);
        chk("dma_ack",   32'(dma_ack),   32'(e.ack));
        chk("dma_rd",    dma_rd,         e.drd);
      end
    end
  end

  initial begin
    logic        g;
    logic        pend;
    logic        pwe;
    logic [31:0] paddr, pwd;
    reset = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wd = 0;
    dma_req = 0; dma_lock = 0; dma_we = 0; dma_addr = 0; dma_wd = 0;
    PrRD = 0;
    // reset with both requesting, then starvation of a single DMA read
    repeat (2)
      step(1, 1, 1, 32'h10, 32'h11, 1, 0, 1, 32'h20, 32'h21, 32'h5, g);
    for (int i = 0; i < 11; i++)
      step(0, 1, 0, 32'h100 + 32'(i), 32'h0, i <= SM, 0, 0,
           32'h7f00, 32'h0, 32'hA000 + 32'(i), g);
    // CPU only write
    step(0, 1, 1, 32'h7f04, 32'h1234, 0, 0, 0, 0, 0, 32'h0, g);
    // DMA only read, then ack/drop
    step(0, 0, 0, 0, 0, 1, 0, 0, 32'h7f00, 0, 32'hCAFE0001, g);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h77, g);
    // starvation into a locked burst
    for (int i = 0; i < 15; i++)
      step(0, 1, 0, 32'h200, 0, 1, 1, 1, 32'h300 + 32'(i),
           32'hD00 + 32'(i), 32'hB000 + 32'(i), g);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, g);
    // reset on the second burst beat
    for (int i = 0; i < 12; i++)
      step(i == SM + 1, 1, 0, 32'h400, 0, 1, 1, 0, 32'h500,
           0, 32'hC000 + 32'(i), g);
    // randomized traffic; DMA attributes held until granted
    pend = 0; pwe = 0; paddr = 0; pwd = 0;
    for (int i = 0; i < 800; i++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1; pwe = 1'($urandom); paddr = $urandom; pwd = $urandom;
      end
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), $urandom, $urandom, pend, 1'($urandom),
           pwe, paddr, pwd, $urandom, g);
      if (g) pend = 0;
    end
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
